// File: rtl/clk_meter.sv
// ---------------------------------------------------------------------------
// clk_meter: frequency and duty-cycle meter for slow or divided clocks.
//
// sig_in is synchronised into the clk domain. The meter first counts rising
// edges over a programmable window (FREQ), then waits for a rising edge
// (ARM), then accumulates high time and rise-to-rise period over N periods
// (DUTY). In DONE both results are compared against the programmed
// expectations.
//
// Optional build macro: CLK_METER_CONTINUOUS_EN
//   undefined : single-shot; each accepted start gives one measurement.
//   defined   : after DONE the meter restarts FREQ with the same latched
//               config; busy stays high and only rst stops it.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   sig_in          asynchronous signal under measurement
//   start           one-cycle request, honoured only in IDLE
//   window_cycles   frequency window in clk cycles (0 acts as 1)
//   num_periods     periods measured in the duty phase (0 acts as 1)
//   exp_edges       expected rising edges in the window
//   edge_tol        allowed |edge_count - exp_edges|
//   busy            measurement in progress
//   done            one-cycle pulse; results valid from this cycle
//   edge_count      rising edges in the window (saturating)
//   high_cycles     accumulated high cycles over the measured periods
//   period_cycles   accumulated rise-to-rise cycles
//   freq_ok         edge count within tolerance
//   duty_ok         duty within tolerance (0 on timeout)
//   timeout         duty phase aborted for lack of rising edges
//
// Handshake: start is sampled only while IDLE; the cycle after it is
// accepted busy rises. done pulses for exactly one cycle in DONE, busy is
// low from that cycle (single-shot), and all result outputs hold their
// values until the next accepted start or rst.
//
// The FSM state is held in state_q (type state_t) for checkers to bind to.
// ---------------------------------------------------------------------------
module clk_meter #(
    parameter int CNT_W          = 16,
    parameter int ACC_W          = CNT_W + 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT        = 4096,
    parameter int DUTY_TOL_SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    input  logic [CNT_W-1:0] window_cycles,
    input  logic [7:0]       num_periods,
    input  logic [CNT_W-1:0] exp_edges,
    input  logic [CNT_W-1:0] edge_tol,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] edge_count,
    output logic [ACC_W-1:0] high_cycles,
    output logic [ACC_W-1:0] period_cycles,
    output logic             freq_ok,
    output logic             duty_ok,
    output logic             timeout
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FREQ = 3'd1,
        S_ARM  = 3'd2,
        S_DUTY = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
    localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT);

    state_t state_q, state_d;

    // Synchronizer and edge detect
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sig_d_q, sig_d_d;
    logic                   sig_s;
    logic                   rise;

    // Latched configuration
    logic [CNT_W-1:0] win_q, win_d;
    logic [7:0]       nper_q, nper_d;
    logic [CNT_W-1:0] exp_edges_q, exp_edges_d;
    logic [CNT_W-1:0] edge_tol_q, edge_tol_d;

    // Working counters: cnt is the FREQ window counter and the ARM timer
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [7:0]       idx_q, idx_d;
    logic [CNT_W-1:0] edge_w_q, edge_w_d;
    logic [ACC_W-1:0] high_acc_q, high_acc_d;
    logic [ACC_W-1:0] per_acc_q, per_acc_d;
    logic             tout_w_q, tout_w_d;

    // Result registers, updated only when a measurement completes
    logic [CNT_W-1:0] edge_count_q, edge_count_d;
    logic [ACC_W-1:0] high_cycles_q, high_cycles_d;
    logic [ACC_W-1:0] period_cycles_q, period_cycles_d;
    logic             freq_ok_q, freq_ok_d;
    logic             duty_ok_q, duty_ok_d;
    logic             timeout_q, timeout_d;

    // Comparison helpers (evaluated on the final working values)
    logic [CNT_W-1:0] edge_diff;
    logic [ACC_W:0]   two_high;
    logic [ACC_W:0]   per_ext;
    logic [ACC_W:0]   duty_diff;
    logic [ACC_W:0]   duty_tol;

    // The high count is taken from sig_s directly, so no falling-edge
    // detector is needed.
    assign sig_s = sync_q[SYNC_STAGES-1];
    assign rise  = sig_s & ~sig_d_q;

    always_comb begin
        state_d         = state_q;
        sync_d          = {sync_q[SYNC_STAGES-2:0], sig_in};
        sig_d_d         = sig_s;
        win_d           = win_q;
        nper_d          = nper_q;
        exp_edges_d     = exp_edges_q;
        edge_tol_d      = edge_tol_q;
        cnt_d           = cnt_q;
        per_cnt_d       = per_cnt_q;
        high_cnt_d      = high_cnt_q;
        idx_d           = idx_q;
        edge_w_d        = edge_w_q;
        high_acc_d      = high_acc_q;
        per_acc_d       = per_acc_q;
        tout_w_d        = tout_w_q;
        edge_count_d    = edge_count_q;
        high_cycles_d   = high_cycles_q;
        period_cycles_d = period_cycles_q;
        freq_ok_d       = freq_ok_q;
        duty_ok_d       = duty_ok_q;
        timeout_d       = timeout_q;
        edge_diff       = '0;
        two_high        = '0;
        per_ext         = '0;
        duty_diff       = '0;
        duty_tol        = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    win_d           = (window_cycles == '0) ? ONE_C : window_cycles;
                    nper_d          = (num_periods == 8'd0) ? 8'd1 : num_periods;
                    exp_edges_d     = exp_edges;
                    edge_tol_d      = edge_tol;
                    cnt_d           = '0;
                    idx_d           = '0;
                    edge_w_d        = '0;
                    high_acc_d      = '0;
                    per_acc_d       = '0;
                    tout_w_d        = 1'b0;
                    edge_count_d    = '0;
                    high_cycles_d   = '0;
                    period_cycles_d = '0;
                    freq_ok_d       = 1'b0;
                    duty_ok_d       = 1'b0;
                    timeout_d       = 1'b0;
                    state_d         = S_FREQ;
                end
            end

            S_FREQ: begin
                if (rise && (edge_w_q != '1)) begin
                    edge_w_d = edge_w_q + ONE_C;
                end
                if (cnt_q == win_q - ONE_C) begin
                    cnt_d   = '0;
                    state_d = S_ARM;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end

            S_ARM: begin
                // The rise cycle is the first cycle of the first period, and
                // sig_s is high in it, so both counters start at 1.
                if (rise) begin
                    per_cnt_d  = ONE_C;
                    high_cnt_d = ONE_C;
                    idx_d      = '0;
                    state_d    = S_DUTY;
                end else if (cnt_q == TMO_C) begin
                    tout_w_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end

            S_DUTY: begin
                if (rise) begin
                    // per/high counts hold the period that just completed.
                    high_acc_d = high_acc_q + ACC_W'(high_cnt_q);
                    per_acc_d  = per_acc_q + ACC_W'(per_cnt_q);
                    idx_d      = idx_q + 8'd1;
                    per_cnt_d  = ONE_C;
                    high_cnt_d = ONE_C;
                    if ((idx_q + 8'd1) == nper_q) begin
                        state_d = S_DONE;
                    end
                end else if (per_cnt_q == TMO_C) begin
                    // No rise for longer than TIMEOUT: keep completed periods only.
                    tout_w_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    per_cnt_d  = per_cnt_q + ONE_C;
                    high_cnt_d = high_cnt_q + CNT_W'(sig_s);
                end
            end

            S_DONE: begin
`ifdef CLK_METER_CONTINUOUS_EN
                cnt_d      = '0;
                idx_d      = '0;
                edge_w_d   = '0;
                high_acc_d = '0;
                per_acc_d  = '0;
                tout_w_d   = 1'b0;
                state_d    = S_FREQ;
`else
                state_d = S_IDLE;
`endif
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Publish results on entry to DONE so they are valid with done.
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            edge_diff = (edge_w_d >= exp_edges_q) ? (edge_w_d - exp_edges_q)
                                                  : (exp_edges_q - edge_w_d);
            two_high  = {high_acc_d, 1'b0};
            per_ext   = {1'b0, per_acc_d};
            duty_diff = (two_high >= per_ext) ? (two_high - per_ext)
                                              : (per_ext - two_high);
            duty_tol  = per_ext >> DUTY_TOL_SHIFT;

            edge_count_d    = edge_w_d;
            high_cycles_d   = high_acc_d;
            period_cycles_d = per_acc_d;
            timeout_d       = tout_w_d;
            freq_ok_d       = (edge_diff <= edge_tol_q);
            duty_ok_d       = !tout_w_d && (duty_diff <= duty_tol);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            sync_q          <= '0;
            sig_d_q         <= 1'b0;
            win_q           <= '0;
            nper_q          <= '0;
            exp_edges_q     <= '0;
            edge_tol_q      <= '0;
            cnt_q           <= '0;
            per_cnt_q       <= '0;
            high_cnt_q      <= '0;
            idx_q           <= '0;
            edge_w_q        <= '0;
            high_acc_q      <= '0;
            per_acc_q       <= '0;
            tout_w_q        <= 1'b0;
            edge_count_q    <= '0;
            high_cycles_q   <= '0;
            period_cycles_q <= '0;
            freq_ok_q       <= 1'b0;
            duty_ok_q       <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            sync_q          <= sync_d;
            sig_d_q         <= sig_d_d;
            win_q           <= win_d;
            nper_q          <= nper_d;
            exp_edges_q     <= exp_edges_d;
            edge_tol_q      <= edge_tol_d;
            cnt_q           <= cnt_d;
            per_cnt_q       <= per_cnt_d;
            high_cnt_q      <= high_cnt_d;
            idx_q           <= idx_d;
            edge_w_q        <= edge_w_d;
            high_acc_q      <= high_acc_d;
            per_acc_q       <= per_acc_d;
            tout_w_q        <= tout_w_d;
            edge_count_q    <= edge_count_d;
            high_cycles_q   <= high_cycles_d;
            period_cycles_q <= period_cycles_d;
            freq_ok_q       <= freq_ok_d;
            duty_ok_q       <= duty_ok_d;
            timeout_q       <= timeout_d;
        end
    end

`ifdef CLK_METER_CONTINUOUS_EN
    assign busy = (state_q != S_IDLE);
`else
    assign busy = (state_q == S_FREQ) || (state_q == S_ARM) || (state_q == S_DUTY);
`endif
    assign done          = (state_q == S_DONE);
    assign edge_count    = edge_count_q;
    assign high_cycles   = high_cycles_q;
    assign period_cycles = period_cycles_q;
    assign freq_ok       = freq_ok_q;
    assign duty_ok       = duty_ok_q;
    assign timeout       = timeout_q;

endmodule

// File: tb/tb_clk_meter.sv
// ---------------------------------------------------------------------------
// tb_clk_meter: self-checking bench for clk_meter.
// A generator drives sig_in as a square wave (hi cycles high, lo cycles low,
// or stuck low when hi is 0). Each measurement pushes the expected result,
// derived from the waveform shape, onto exp_q; the monitor pops and compares
// whenever done pulses.
// ---------------------------------------------------------------------------
module tb_clk_meter;

    localparam int CNT_W = 16;
    localparam int ACC_W = 24;
    localparam int WAIT_LIMIT = 20000;

    logic             clk = 1'b0;
    logic             rst;
    logic             sig_in;
    logic             start;
    logic [CNT_W-1:0] window_cycles;
    logic [7:0]       num_periods;
    logic [CNT_W-1:0] exp_edges;
    logic [CNT_W-1:0] edge_tol;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] edge_count;
    logic [ACC_W-1:0] high_cycles;
    logic [ACC_W-1:0] period_cycles;
    logic             freq_ok;
    logic             duty_ok;
    logic             timeout;

    typedef struct packed {
        logic [CNT_W-1:0] e_lo;
        logic [CNT_W-1:0] e_hi;
        logic [ACC_W-1:0] high;
        logic [ACC_W-1:0] per;
        logic             f_any;
        logic             f_ok;
        logic             d_ok;
        logic             tmo;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    logic [EXP_W-1:0] exp_q[$];
    exp_t             mon_e;

    int n_chk  = 0;
    int n_pass = 0;
    int n_done = 0;

    int gen_hi = 3;
    int gen_lo = 3;
    int gen_ph = 0;

    clk_meter dut (
        .clk           (clk),
        .rst           (rst),
        .sig_in        (sig_in),
        .start         (start),
        .window_cycles (window_cycles),
        .num_periods   (num_periods),
        .exp_edges     (exp_edges),
        .edge_tol      (edge_tol),
        .busy          (busy),
        .done          (done),
        .edge_count    (edge_count),
        .high_cycles   (high_cycles),
        .period_cycles (period_cycles),
        .freq_ok       (freq_ok),
        .duty_ok       (duty_ok),
        .timeout       (timeout)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- square-wave generator ----------------
    initial begin
        sig_in = 1'b0;
        forever begin
            @(negedge clk);
            if (gen_hi == 0) begin
                sig_in = 1'b0;
            end else begin
                if (gen_ph >= gen_hi + gen_lo) gen_ph = 0;
                sig_in = (gen_ph < gen_hi);
                gen_ph++;
            end
        end
    end

    // ---------------- check helpers ----------------
    task automatic check(input string name, input logic pass, input longint act, input longint exp);
        n_chk++;
        if (pass) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_rng(input string name, input longint act, input longint lo, input longint hi);
        n_chk++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    function automatic longint absdiff(input longint a, input longint b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Reference model: results follow from the waveform shape alone. Any run
    // of W consecutive cycles of a period-P wave holds floor(W/P) or
    // ceil(W/P) rising edges; every full period has hi high cycles.
    function automatic exp_t model(input int hi, input int lo, input int win,
                                   input int np, input int ee, input int tol);
        exp_t   e;
        int     p, ew, en;
        longint h2, pr;
        logic   ok_lo, ok_hi;
        ew = (win == 0) ? 1 : win;
        en = (np == 0) ? 1 : np;
        if (hi == 0) begin
            e.e_lo = '0;
            e.e_hi = '0;
            e.high = '0;
            e.per  = '0;
            e.tmo  = 1'b1;
            e.d_ok = 1'b0;
        end else begin
            p      = hi + lo;
            e.e_lo = CNT_W'(ew / p);
            e.e_hi = CNT_W'((ew + p - 1) / p);
            e.high = ACC_W'(hi * en);
            e.per  = ACC_W'(p * en);
            e.tmo  = 1'b0;
            h2     = 2 * longint'(hi * en);
            pr     = longint'(p * en);
            e.d_ok = (absdiff(h2, pr) <= (pr / 16));
        end
        ok_lo   = (absdiff(longint'(e.e_lo), longint'(ee)) <= tol);
        ok_hi   = (absdiff(longint'(e.e_hi), longint'(ee)) <= tol);
        e.f_any = (ok_lo != ok_hi);
        e.f_ok  = ok_lo;
        return e;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1'b0, 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_rng("edge_count", edge_count, mon_e.e_lo, mon_e.e_hi);
                check("high_cycles", high_cycles == mon_e.high, high_cycles, mon_e.high);
                check("period_cycles", period_cycles == mon_e.per, period_cycles, mon_e.per);
                check("timeout", timeout == mon_e.tmo, timeout, mon_e.tmo);
                check("duty_ok", duty_ok == mon_e.d_ok, duty_ok, mon_e.d_ok);
                if (!mon_e.f_any)
                    check("freq_ok", freq_ok == mon_e.f_ok, freq_ok, mon_e.f_ok);
`ifndef CLK_METER_CONTINUOUS_EN
                check("busy_at_done", busy == 1'b0, busy, 0);
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_wave(input int hi, input int lo);
        gen_hi = hi;
        gen_lo = lo;
        repeat (20 + $urandom_range(0, 7)) @(negedge clk);
    endtask

    task automatic pulse_start(input int win, input int np, input int ee, input int tol);
        window_cycles = CNT_W'(win);
        num_periods   = 8'(np);
        exp_edges     = CNT_W'(ee);
        edge_tol      = CNT_W'(tol);
        start         = 1'b1;
        @(negedge clk);
        start         = 1'b0;
    endtask

    // One single-shot measurement; poke re-issues start while busy with a
    // very different config that must be ignored.
    task automatic run_meas(input int hi, input int lo, input int win, input int np,
                            input int ee, input int tol, input bit poke, output int lat);
        int d0;
        set_wave(hi, lo);
        exp_q.push_back(model(hi, lo, win, np, ee, tol));
        d0 = n_done;
        pulse_start(win, np, ee, tol);
        check("busy_after_start", busy == 1'b1, busy, 1);
        lat = 1;
        if (poke) begin
            @(negedge clk);
            lat++;
            pulse_start(600, 10, 100, 1);
            lat++;
        end
        while (done !== 1'b1 && lat < WAIT_LIMIT) begin
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) check("done_wait", 1'b0, lat, WAIT_LIMIT);
        repeat (12) @(negedge clk);
        check("done_once", (n_done - d0) == 1, n_done - d0, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat, hi, lo, win, np, ee, tol, p, k;
        rst = 1'b1;
        start = 1'b0;
        window_cycles = '0;
        num_periods = '0;
        exp_edges = '0;
        edge_tol = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_busy", busy == 1'b0, busy, 0);
        check("rst_done", done == 1'b0, done, 0);
        check("rst_edge_count", edge_count == '0, edge_count, 0);
        check("rst_high", high_cycles == '0, high_cycles, 0);
        check("rst_period", period_cycles == '0, period_cycles, 0);
        check("rst_flags", {freq_ok, duty_ok, timeout} == 3'b000, {freq_ok, duty_ok, timeout}, 0);

`ifdef CLK_METER_CONTINUOUS_EN
        begin
            int busy_low, d0, cyc;
            set_wave(3, 3);
            repeat (3) exp_q.push_back(model(3, 3, 60, 4, 10, 1));
            d0 = n_done;
            busy_low = 0;
            cyc = 0;
            pulse_start(60, 4, 10, 1);
            while ((n_done - d0) < 3 && cyc < WAIT_LIMIT) begin
                if (busy !== 1'b1) busy_low++;
                @(negedge clk);
                cyc++;
            end
            check("cont_dones", (n_done - d0) == 3, n_done - d0, 3);
            check("cont_busy_low_cycles", busy_low == 0, busy_low, 0);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("cont_busy_after_rst", busy == 1'b0, busy, 0);
        end
`else
        // clk/6 square wave
        run_meas(3, 3, 600, 10, 100, 1, 1'b0, lat);
        // clk/5 with 1 high: poor duty, too many edges
        run_meas(1, 4, 600, 8, 100, 1, 1'b0, lat);

        // reset in the middle of FREQ
        set_wave(3, 3);
        pulse_start(600, 10, 100, 1);
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy == 1'b0, busy, 0);
        check("midrst_done", done == 1'b0, done, 0);
        check("midrst_results", (edge_count == '0) && (high_cycles == '0) && (period_cycles == '0),
              edge_count + high_cycles + period_cycles, 0);
        check("midrst_flags", {freq_ok, duty_ok, timeout} == 3'b000, {freq_ok, duty_ok, timeout}, 0);
        repeat (700) @(negedge clk);
        check("midrst_no_done", done == 1'b0 && busy == 1'b0, {busy, done}, 0);
        run_meas(3, 3, 600, 10, 100, 1, 1'b0, lat);

        // stuck low: window then ARM timeout
        run_meas(0, 0, 100, 1, 5, 1, 1'b0, lat);
        check_rng("stuck_done_latency", lat, 100 + 4096 + 1, 100 + 4096 + 3);

        // zero window / zero periods, second start while busy
        run_meas(3, 3, 0, 0, 0, 1, 1'b1, lat);

        // randomized waveforms and configs
        for (int i = 0; i < 8; i++) begin
            hi  = $urandom_range(1, 6);
            lo  = $urandom_range(1, 6);
            win = $urandom_range(1, 300);
            np  = $urandom_range(1, 12);
            p   = hi + lo;
            k   = win / p;
            ee  = k + $urandom_range(0, 4) - 2;
            if (ee < 0) ee = 0;
            tol = $urandom_range(0, 2);
            run_meas(hi, lo, win, np, ee, tol, 1'b0, lat);
        end
`endif

        check("leftover_expect", exp_q.size() == 0, exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/clk_meter.md
Name: clk_meter

Overview:
- Synthesizable on-chip frequency and duty-cycle meter for divided clocks, such as divider outputs or slow strobes.
- Samples an asynchronous input in the `clk` domain and counts rising edges over a programmable window.
- Then accumulates high time and period over N periods, and compares both against programmed expectations.
- Acts as the hardware checker counterpart to the clock-divider blocks, for built-in self-test and runtime clock supervision.

Parameters:
- CNT_W, 16, width of window, edge, timeout and per-period counters.
- ACC_W, CNT_W+8, width of the high-time and period accumulators. Sized so 255 periods of up to 2^CNT_W cycles cannot overflow.
- SYNC_STAGES, 2, flops in the `sig_in` synchronizer (minimum 2).
- TIMEOUT, 4096, cycles allowed between rising edges during the duty phase before aborting.
- DUTY_TOL_SHIFT, 4, duty tolerance: |2*high - period| <= period >> DUTY_TOL_SHIFT (6.25% of period).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- sig_in  in  1  asynchronous signal under measurement.
- start  in  1  single-cycle measurement request; honoured only in IDLE.
- window_cycles  in  CNT_W  frequency window length in clk cycles; 0 is treated as 1.
- num_periods  in  8  periods for the duty phase; 0 is treated as 1.
- exp_edges  in  CNT_W  expected rising edges in the window.
- edge_tol  in  CNT_W  allowed |edge_count - exp_edges|.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; results are valid from this cycle.
- edge_count  out  CNT_W  rising edges counted in the window; saturating.
- high_cycles  out  ACC_W  accumulated high cycles over the measured periods.
- period_cycles  out  ACC_W  accumulated rise-to-rise cycles.
- freq_ok  out  1  edge count within tolerance.
- duty_ok  out  1  duty within tolerance.
- timeout  out  1  duty phase aborted; duty_ok forced 0.

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-high, port names `clk` and `rst`.
  - On `rst` all outputs, counters, accumulators and synchronizer flops are 0 and the FSM is IDLE.
  - Reset mid-measurement discards all partial results.
- Edge detect:
  - `sig_s` is the last synchronizer stage and `sig_d` is `sig_s` delayed one cycle.
  - `rise = sig_s & ~sig_d`, `fall = ~sig_s & sig_d`.
  - Latency from a `sig_in` transition to detection is SYNC_STAGES+1 cycles.
- FSM states are IDLE, FREQ, ARM, DUTY, DONE.
- IDLE:
  - `start` latches all config inputs.
  - Clears `edge_count`, the accumulators and all flags.
  - Moves to FREQ; `busy` goes high the next cycle.
  - `start` while not IDLE is ignored.
- FREQ:
  - Runs for exactly max(window_cycles,1) cycles.
  - Each `rise`, including one on the final cycle, increments `edge_count`.
  - Then goes to ARM.
- ARM:
  - Waits for `rise`, then goes to DUTY with the period counter at 1 and the period index at 0.
  - No `rise` within TIMEOUT cycles goes to DONE with `timeout=1`.
- DUTY:
  - Each cycle adds 1 to the running period count, and adds `sig_s` to the high count.
  - On `rise`, the completed period is added to `period_cycles` and `high_cycles`, and the index increments.
  - When the index reaches max(num_periods,1), go to DONE.
  - A gap of more than TIMEOUT cycles since the last `rise` goes to DONE with `timeout=1`; accumulators hold the completed periods only.
- DONE (one cycle):
  - `done=1`, `busy=0` from this cycle, then return to IDLE.
  - `freq_ok = |edge_count - exp_edges| <= edge_tol`, evaluated with unsigned difference (larger minus smaller).
  - `duty_ok = !timeout && |2*high_cycles - period_cycles| <= (period_cycles >> DUTY_TOL_SHIFT)`.
- Results and flags hold until the next accepted `start` or `rst`.
- `start` asserted in the DONE cycle is ignored; it is accepted in the following IDLE cycle.

Optional Feature:
- Macro: CLK_METER_CONTINUOUS_EN.
- Defined:
  - DONE returns directly to FREQ with the same latched config; `busy` stays high.
  - `done` pulses once per measurement, with results updated at each `done`.
  - `start` is ignored while running; only `rst` stops the meter.
- Undefined: single-shot operation exactly as described in Behaviour.

Test Plan:
- Square wave sig_in = clk/6 (3 high, 3 low), window_cycles=600, exp_edges=100, edge_tol=1, num_periods=10 -> edge_count 99..101, high_cycles=30, period_cycles=60, freq_ok=1, duty_ok=1, done pulses exactly once.
- sig_in = clk/5 (1 high, 4 low), num_periods=8 -> high_cycles=8, period_cycles=40, duty_ok=0. With exp_edges=100 and window 600 -> edge_count≈120, freq_ok=0.
- sig_in stuck at 0, TIMEOUT=4096, window_cycles=100 -> edge_count=0, timeout=1, duty_ok=0, done exactly 100+4096+2 (±1) cycles after start.
- rst asserted mid-FREQ on a clk/6 input -> next cycle all outputs 0, busy=0; a new start yields a full, correct measurement.
- start pulsed again while busy, plus window_cycles=0 and num_periods=0 -> second start ignored; FREQ lasts 1 cycle; duty phase measures 1 period (period_cycles=6 for clk/6).
- With CLK_METER_CONTINUOUS_EN and sig_in clk/6, window 60 -> done pulses periodically with edge_count 9..11 each time; busy never drops until rst.
